lsq_controller: RTL

- Load/store queue and data-memory sequencer sitting between the execute stage and the single data-memory port.
- Accepts committed load/store entries from the execute stage into an in-order queue and issues them one at a time to memory over a req/gnt/rvalid handshake.
- Formats store byte-lanes and data, and returns sign/zero-extended load data to register-file write-back.
- Back-pressures the execute stage through lsq_full_o.

---
 rtl/lsq_controller_pkg.sv | 32 +++
 rtl/lsq_fifo.sv | 58 +++++
 rtl/lsq_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lsq_controller_pkg.sv
// Shared definitions for the load/store queue: funct3 codes, FSM states and queue entry layout.
package lsq_controller_pkg;

    localparam int unsigned LSQ_XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSQ_IDLE = 2'd0,
        LSQ_REQ  = 2'd1,
        LSQ_RSP  = 2'd2
    } lsq_state_t;

    typedef struct packed {
        logic                is_store;
        logic [1:0]          hpl;
        logic [2:0]          funct3;
        logic [4:0]          regd_addr;
        logic [LSQ_XLEN-1:0] addr;
        logic [LSQ_XLEN-1:0] data;
    } lsq_entry_t;

    localparam int unsigned LSQ_ENTRY_W = $bits(lsq_entry_t);

endpackage

// File: rtl/lsq_fifo.sv
// Synchronous DEPTH-entry FIFO with count/full/empty and a look-ahead of the head after a pop.
module lsq_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_after_pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // With a single entry left, the next head can only be the entry being pushed this cycle.
    assign head_after_pop = (count > CW'(1)) ? mem[rd_ptr + PW'(1)] : push_data;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/lsq_controller.sv
// In-order load/store queue that issues one access at a time to the data-memory port
// and returns extended load data to register write-back.
module lsq_controller
    import lsq_controller_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = LSQ_XLEN
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clk_en_i,
    input  logic            exs_lq_wr_i,
    input  logic            exs_sq_wr_i,
    input  logic [1:0]      exs_hpl_i,
    input  logic [2:0]      exs_funct3_i,
    input  logic [4:0]      exs_regd_addr_i,
    input  logic [XLEN-1:0] exs_regs2_data_i,
    input  logic [XLEN-1:0] exs_addr_i,
    output logic            lsq_full_o,
    output logic            lsq_empty_o,
    output logic            dmem_req_o,
    input  logic            dmem_gnt_i,
    output logic            dmem_wr_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [1:0]      dmem_hpl_o,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    input  logic            dmem_err_i,
    output logic            wb_regd_wr_o,
    output logic [4:0]      wb_regd_addr_o,
    output logic [XLEN-1:0] wb_regd_data_o,
    output logic            err_o,
    output logic            err_store_o,
    output logic [XLEN-1:0] err_addr_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    lsq_state_t      state;
    lsq_entry_t      push_entry;
    lsq_entry_t      head;
    lsq_entry_t      head_after_pop;
    lsq_entry_t      req_src;
    logic [CW-1:0]   count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            more_after_pop;
    logic            issue;
    logic [3:0]      req_be;
    logic [XLEN-1:0] req_wdata;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic            unused_bits;

    assign push_entry = '{is_store:  exs_sq_wr_i,
                          hpl:       exs_hpl_i,
                          funct3:    exs_funct3_i,
                          regd_addr: exs_regd_addr_i,
                          addr:      exs_addr_i,
                          data:      exs_regs2_data_i};

    assign push           = (exs_lq_wr_i || exs_sq_wr_i) && clk_en_i && !fifo_full;
    assign pop            = clk_en_i && (state == LSQ_RSP) && dmem_rvalid_i;
    assign more_after_pop = (count > CW'(1)) || push;
    assign issue          = ((state == LSQ_IDLE) && !fifo_empty) || (pop && more_after_pop);

    lsq_fifo #(
        .WIDTH (LSQ_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk_i),
        .reset          (reset_i),
        .push           (push),
        .push_data      (push_entry),
        .pop            (pop),
        .head           (head),
        .head_after_pop (head_after_pop),
        .count          (count),
        .full           (fifo_full),
        .empty          (fifo_empty)
    );

    assign lsq_full_o  = fifo_full;
    assign lsq_empty_o = fifo_empty && (state == LSQ_IDLE);

    // Next request comes from the entry behind the head when the head retires this cycle.
    assign req_src = (state == LSQ_RSP) ? head_after_pop : head;

    always_comb begin
        req_be    = 4'b1111;
        req_wdata = req_src.data;
        case (req_src.funct3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << req_src.addr[1:0];
                req_wdata = {4{req_src.data[7:0]}};
            end
            2'b01: begin
                req_be    = 4'b0011 << {req_src.addr[1], 1'b0};
                req_wdata = {2{req_src.data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = '0;
        shifted   = dmem_rdata_i >> {head.addr[1:0], 3'b000};
        case (head.funct3)
            F3_LB:   load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data = shifted;
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    assign unused_bits = ^{req_src.regd_addr, req_src.funct3[2], head.hpl, head.data};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= LSQ_IDLE;
            dmem_req_o     <= 1'b0;
            dmem_wr_o      <= 1'b0;
            dmem_addr_o    <= '0;
            dmem_be_o      <= '0;
            dmem_wdata_o   <= '0;
            dmem_hpl_o     <= '0;
            wb_regd_wr_o   <= 1'b0;
            wb_regd_addr_o <= '0;
            wb_regd_data_o <= '0;
            err_o          <= 1'b0;
            err_store_o    <= 1'b0;
            err_addr_o     <= '0;
        end else if (clk_en_i) begin
            wb_regd_wr_o <= 1'b0;
            err_o        <= 1'b0;
            case (state)
                LSQ_IDLE: begin
                    if (!fifo_empty) begin
                        state      <= LSQ_REQ;
                        dmem_req_o <= 1'b1;
                    end
                end
                LSQ_REQ: begin
                    if (dmem_gnt_i) begin
                        state      <= LSQ_RSP;
                        dmem_req_o <= 1'b0;
                    end
                end
                LSQ_RSP: begin
                    if (dmem_rvalid_i) begin
                        if (dmem_err_i) begin
                            err_o       <= 1'b1;
                            err_store_o <= head.is_store;
                            err_addr_o  <= head.addr;
                        end else if (!head.is_store) begin
                            wb_regd_wr_o   <= 1'b1;
                            wb_regd_addr_o <= head.regd_addr;
                            wb_regd_data_o <= load_data;
                        end
                        state      <= more_after_pop ? LSQ_REQ : LSQ_IDLE;
                        dmem_req_o <= more_after_pop;
                    end
                end
                default: begin
                    state      <= LSQ_IDLE;
                    dmem_req_o <= 1'b0;
                end
            endcase
            // Request payload is captured once and held until the grant.
            if (issue) begin
                dmem_wr_o    <= req_src.is_store;
                dmem_addr_o  <= {req_src.addr[XLEN-1:2], 2'b00};
                dmem_be_o    <= req_be;
                dmem_wdata_o <= req_wdata;
                dmem_hpl_o   <= req_src.hpl;
            end
        end
    end

    // Both push strobes at once is an execute-stage bug; the entry is treated as a store.
    assert property (@(posedge clk_i) disable iff (reset_i)
        !(clk_en_i && exs_lq_wr_i && exs_sq_wr_i));

endmodule
